// File: rtl/ccip_if_pkg.sv
// CCI-P channel bundles shared by the interface pipe and the AFU.
// Rx carries FIU responses/MMIO and almost-fulls; Tx carries AFU requests.
package ccip_if_pkg;

    typedef struct packed {
        logic [1:0]  vc_used;
        logic        hit_miss;
        logic [1:0]  cl_num;
        logic [3:0]  resp_type;
        logic [15:0] mdata;
    } t_ccip_c0_RspHdr;

    typedef struct packed {
        logic [1:0]  vc_used;
        logic        hit_miss;
        logic        format;
        logic [1:0]  cl_num;
        logic [3:0]  resp_type;
        logic [15:0] mdata;
    } t_ccip_c1_RspHdr;

    typedef struct packed {
        logic [1:0]  vc_sel;
        logic [1:0]  cl_len;
        logic [3:0]  req_type;
        logic [41:0] address;
        logic [15:0] mdata;
    } t_ccip_c0_ReqHdr;

    typedef struct packed {
        logic [1:0]  vc_sel;
        logic        sop;
        logic [1:0]  cl_len;
        logic [3:0]  req_type;
        logic [41:0] address;
        logic [15:0] mdata;
    } t_ccip_c1_ReqHdr;

    typedef struct packed {
        logic [8:0] tid;
    } t_ccip_c2_RspHdr;

    typedef struct packed {
        t_ccip_c0_RspHdr hdr;
        logic [511:0]    data;
        logic            rspValid;
        logic            mmioRdValid;
        logic            mmioWrValid;
    } t_if_ccip_c0_Rx;

    typedef struct packed {
        t_ccip_c1_RspHdr hdr;
        logic            rspValid;
    } t_if_ccip_c1_Rx;

    typedef struct packed {
        t_ccip_c0_ReqHdr hdr;
        logic            valid;
    } t_if_ccip_c0_Tx;

    typedef struct packed {
        t_ccip_c1_ReqHdr hdr;
        logic [511:0]    data;
        logic            valid;
    } t_if_ccip_c1_Tx;

    typedef struct packed {
        t_ccip_c2_RspHdr hdr;
        logic [63:0]     data;
        logic            mmioRdValid;
    } t_if_ccip_c2_Tx;

    typedef struct packed {
        logic           c0TxAlmFull;
        logic           c1TxAlmFull;
        t_if_ccip_c0_Rx c0;
        t_if_ccip_c1_Rx c1;
    } t_if_ccip_Rx;

    typedef struct packed {
        t_if_ccip_c0_Tx c0;
        t_if_ccip_c1_Tx c1;
        t_if_ccip_c2_Tx c2;
    } t_if_ccip_Tx;

endpackage

// File: rtl/ccip_interface_pipe.sv
// CCI-P boundary retiming: Rx/Tx register pipes, stretched AFU reset,
// sticky error / power-state monitor and per-channel almost-full checks.
// Ports: pClk, pck_cp2af_softReset_n (async low) in; FIU pwr/error/sRx and
// AFU sTx in; AFU reset, pwrState, sticky error, sRx/sTx, viol flags,
// pwr_change_cnt out.
module ccip_interface_pipe
    import ccip_if_pkg::*;
#(
    parameter int unsigned RX_STAGES     = 1,
    parameter int unsigned TX_STAGES     = 1,
    parameter int unsigned RST_STRETCH   = 16,
    parameter int unsigned ALMFULL_SLACK = 8
) (
    input  logic        pClk,
    input  logic        pck_cp2af_softReset_n,
    input  logic [1:0]  pck_cp2af_pwrState_T0,
    input  logic        pck_cp2af_error_T0,
    input  t_if_ccip_Rx pck_cp2af_sRx_T0,
    input  t_if_ccip_Tx pck_af2cp_sTx_T0,
    output logic        pck_cp2af_softReset_Tn,
    output logic [1:0]  pck_cp2af_pwrState_Tn,
    output logic        pck_cp2af_error_sticky,
    output t_if_ccip_Rx pck_cp2af_sRx_Tn,
    output t_if_ccip_Tx pck_af2cp_sTx_Tn,
    output logic        c0_almfull_viol,
    output logic        c1_almfull_viol,
    output logic [7:0]  pwr_change_cnt
);

    localparam logic [7:0] STRETCH8 = 8'(RST_STRETCH);
    localparam logic [6:0] SLACK7   = 7'(ALMFULL_SLACK);
    // Rx flags: {c0AF, c1AF, c0.rsp, c0.mmioRd, c0.mmioWr, c1.rsp}
    localparam logic [5:0] RX_FL_RST = 6'b110000;

    // ---------------- internal reset ----------------
    logic [1:0] rst_sync_q;
    logic       rst_ni;
    logic       rst_i;

    always_ff @(posedge pClk or negedge pck_cp2af_softReset_n) begin
        if (!pck_cp2af_softReset_n) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    // Assert is asynchronous, release is two clocks later.
    assign rst_ni = rst_sync_q[1];
    assign rst_i  = ~rst_ni;

    // ---------------- reset stretcher ----------------
    logic [7:0] stretch_q;
    logic [7:0] stretch_d;

    always_comb begin
        stretch_d = stretch_q;
        if (stretch_q != 8'd0) begin
            stretch_d = stretch_q - 8'd1;
        end
    end

    always_ff @(posedge pClk or negedge rst_ni) begin
        if (!rst_ni) begin
            stretch_q <= STRETCH8;
        end else begin
            stretch_q <= stretch_d;
        end
    end

    assign pck_cp2af_softReset_Tn = rst_i | (stretch_q != 8'd0);

    // ---------------- Rx pipeline ----------------
    t_if_ccip_Rx rx_pl_q [RX_STAGES];
    logic [5:0]  rx_fl_q [RX_STAGES];
    logic [5:0]  rx_fl_in;

    assign rx_fl_in = {pck_cp2af_sRx_T0.c0TxAlmFull,
                       pck_cp2af_sRx_T0.c1TxAlmFull,
                       pck_cp2af_sRx_T0.c0.rspValid,
                       pck_cp2af_sRx_T0.c0.mmioRdValid,
                       pck_cp2af_sRx_T0.c0.mmioWrValid,
                       pck_cp2af_sRx_T0.c1.rspValid};

    // Payload registers carry no reset; only the flags below do.
    always_ff @(posedge pClk) begin
        rx_pl_q[0] <= pck_cp2af_sRx_T0;
        for (int unsigned i = 1; i < RX_STAGES; i++) begin
            rx_pl_q[i] <= rx_pl_q[i-1];
        end
    end

    always_ff @(posedge pClk or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < RX_STAGES; i++) begin
                rx_fl_q[i] <= RX_FL_RST;
            end
        end else begin
            rx_fl_q[0] <= rx_fl_in;
            for (int unsigned i = 1; i < RX_STAGES; i++) begin
                rx_fl_q[i] <= rx_fl_q[i-1];
            end
        end
    end

    always_comb begin
        pck_cp2af_sRx_Tn                = rx_pl_q[RX_STAGES-1];
        pck_cp2af_sRx_Tn.c0TxAlmFull    = rx_fl_q[RX_STAGES-1][5];
        pck_cp2af_sRx_Tn.c1TxAlmFull    = rx_fl_q[RX_STAGES-1][4];
        pck_cp2af_sRx_Tn.c0.rspValid    = rx_fl_q[RX_STAGES-1][3];
        pck_cp2af_sRx_Tn.c0.mmioRdValid = rx_fl_q[RX_STAGES-1][2];
        pck_cp2af_sRx_Tn.c0.mmioWrValid = rx_fl_q[RX_STAGES-1][1];
        pck_cp2af_sRx_Tn.c1.rspValid    = rx_fl_q[RX_STAGES-1][0];
    end

    // ---------------- Tx pipeline ----------------
    t_if_ccip_Tx tx_pl_q [TX_STAGES];
    logic [2:0]  tx_fl_q [TX_STAGES];
    logic [2:0]  tx_fl_in;

    // A resetting AFU must never get a request out to the FIU.
    assign tx_fl_in = {pck_af2cp_sTx_T0.c0.valid,
                       pck_af2cp_sTx_T0.c1.valid,
                       pck_af2cp_sTx_T0.c2.mmioRdValid}
                      & {3{~pck_cp2af_softReset_Tn}};

    always_ff @(posedge pClk) begin
        tx_pl_q[0] <= pck_af2cp_sTx_T0;
        for (int unsigned i = 1; i < TX_STAGES; i++) begin
            tx_pl_q[i] <= tx_pl_q[i-1];
        end
    end

    always_ff @(posedge pClk or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < TX_STAGES; i++) begin
                tx_fl_q[i] <= 3'b000;
            end
        end else begin
            tx_fl_q[0] <= tx_fl_in;
            for (int unsigned i = 1; i < TX_STAGES; i++) begin
                tx_fl_q[i] <= tx_fl_q[i-1];
            end
        end
    end

    always_comb begin
        pck_af2cp_sTx_Tn                = tx_pl_q[TX_STAGES-1];
        pck_af2cp_sTx_Tn.c0.valid       = tx_fl_q[TX_STAGES-1][2];
        pck_af2cp_sTx_Tn.c1.valid       = tx_fl_q[TX_STAGES-1][1];
        pck_af2cp_sTx_Tn.c2.mmioRdValid = tx_fl_q[TX_STAGES-1][0];
    end

    // ---------------- almost-full checkers ----------------
    logic [1:0] af_in;
    logic [1:0] af_vld;
    logic [6:0] afcnt_q [2];
    logic [6:0] afcnt_d [2];
    logic [1:0] viol_q;
    logic [1:0] viol_d;

    // Requests are counted where they leave toward the FIU.
    assign af_in  = {pck_cp2af_sRx_T0.c1TxAlmFull,
                     pck_cp2af_sRx_T0.c0TxAlmFull};
    assign af_vld = {pck_af2cp_sTx_Tn.c1.valid,
                     pck_af2cp_sTx_Tn.c0.valid};

    always_comb begin
        for (int c = 0; c < 2; c++) begin
            afcnt_d[c] = afcnt_q[c];
            if (!af_in[c]) begin
                afcnt_d[c] = 7'd0;
            end else if (af_vld[c] && (afcnt_q[c] != 7'h7f)) begin
                afcnt_d[c] = afcnt_q[c] + 7'd1;
            end
            viol_d[c] = viol_q[c] | (afcnt_d[c] > SLACK7);
        end
    end

    always_ff @(posedge pClk or negedge rst_ni) begin
        if (!rst_ni) begin
            afcnt_q[0] <= 7'd0;
            afcnt_q[1] <= 7'd0;
            viol_q     <= 2'b00;
        end else begin
            afcnt_q[0] <= afcnt_d[0];
            afcnt_q[1] <= afcnt_d[1];
            viol_q     <= viol_d;
        end
    end

    assign c0_almfull_viol = viol_q[0];
    assign c1_almfull_viol = viol_q[1];

    // ---------------- error / power monitor ----------------
    logic       err_q;
    logic       err_d;
    logic [1:0] pwr_q;
    logic [7:0] pwr_cnt_q;
    logic [7:0] pwr_cnt_d;

    always_comb begin
        err_d     = err_q | pck_cp2af_error_T0;
        pwr_cnt_d = pwr_cnt_q;
        if ((pwr_q != pck_cp2af_pwrState_T0) && (pwr_cnt_q != 8'hff)) begin
            pwr_cnt_d = pwr_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge pClk or negedge rst_ni) begin
        if (!rst_ni) begin
            err_q     <= 1'b0;
            pwr_q     <= 2'b00;
            pwr_cnt_q <= 8'd0;
        end else begin
            err_q     <= err_d;
            pwr_q     <= pck_cp2af_pwrState_T0;
            pwr_cnt_q <= pwr_cnt_d;
        end
    end

    assign pck_cp2af_error_sticky = err_q;
    assign pck_cp2af_pwrState_Tn  = pwr_q;
    assign pwr_change_cnt         = pwr_cnt_q;

endmodule

// File: tb/tb_ccip_interface_pipe.sv
// Bench for ccip_interface_pipe: directed vectors, a queue-based model
// checked every cycle, and literal expectations at key points.
module tb_ccip_interface_pipe;
    import ccip_if_pkg::*;

    localparam int RX = 3;
    localparam int TX = 2;
    localparam int S  = 16;
    localparam int SL = 8;

    logic        pClk;
    logic        rst_n;
    logic [1:0]  pwr_in;
    logic        err_in;
    t_if_ccip_Rx rx_in;
    t_if_ccip_Tx tx_in;
    logic        sr_o;
    logic [1:0]  pwr_o;
    logic        err_o;
    t_if_ccip_Rx rx_o;
    t_if_ccip_Tx tx_o;
    logic        v0_o;
    logic        v1_o;
    logic [7:0]  pcnt_o;

    ccip_interface_pipe #(
        .RX_STAGES    (RX),
        .TX_STAGES    (TX),
        .RST_STRETCH  (S),
        .ALMFULL_SLACK(SL)
    ) dut (
        .pClk                  (pClk),
        .pck_cp2af_softReset_n (rst_n),
        .pck_cp2af_pwrState_T0 (pwr_in),
        .pck_cp2af_error_T0    (err_in),
        .pck_cp2af_sRx_T0      (rx_in),
        .pck_af2cp_sTx_T0      (tx_in),
        .pck_cp2af_softReset_Tn(sr_o),
        .pck_cp2af_pwrState_Tn (pwr_o),
        .pck_cp2af_error_sticky(err_o),
        .pck_cp2af_sRx_Tn      (rx_o),
        .pck_af2cp_sTx_Tn      (tx_o),
        .c0_almfull_viol       (v0_o),
        .c1_almfull_viol       (v1_o),
        .pwr_change_cnt        (pcnt_o)
    );

    initial pClk = 1'b0;
    always #5 pClk = ~pClk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [639:0] act,
                       input logic [639:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    t_if_ccip_Rx rxq[$];
    t_if_ccip_Tx txq[$];
    int          rel;
    int          afc0, afc1;
    bit          m_v0, m_v1, m_err;
    logic [1:0]  m_pw;
    int          m_pcnt;
    int          beats = 0;
    int          run = 0;
    int          maxrun = 0;

    function automatic t_if_ccip_Rx kill_rx(input t_if_ccip_Rx r);
        t_if_ccip_Rx k = r;
        k.c0.rspValid    = 1'b0;
        k.c0.mmioRdValid = 1'b0;
        k.c0.mmioWrValid = 1'b0;
        k.c1.rspValid    = 1'b0;
        k.c0TxAlmFull    = 1'b1;
        k.c1TxAlmFull    = 1'b1;
        return k;
    endfunction

    function automatic t_if_ccip_Tx kill_tx(input t_if_ccip_Tx t);
        t_if_ccip_Tx k = t;
        k.c0.valid       = 1'b0;
        k.c1.valid       = 1'b0;
        k.c2.mmioRdValid = 1'b0;
        return k;
    endfunction

    task automatic m_reset();
        rel = 0;
        if (rxq.size() == 0) begin
            for (int i = 0; i < RX; i++) rxq.push_back(kill_rx('0));
            for (int i = 0; i < TX; i++) txq.push_back(kill_tx('0));
        end
        foreach (rxq[i]) rxq[i] = kill_rx(rxq[i]);
        foreach (txq[i]) txq[i] = kill_tx(txq[i]);
        afc0 = 0; afc1 = 0;
        m_v0 = 0; m_v1 = 0; m_err = 0;
        m_pw = 2'd0; m_pcnt = 0;
    endtask

    task automatic m_edge();
        int rb = rel;
        bit cap, srb;
        t_if_ccip_Tx txo = txq[0];
        if (rel < 1000) rel++;
        cap = (rel >= 3);
        srb = (rb < 2 + S);
        if (!cap) begin
            afc0 = 0; afc1 = 0;
            m_v0 = 0; m_v1 = 0; m_err = 0;
            m_pw = 2'd0; m_pcnt = 0;
        end else begin
            if (!rx_in.c0TxAlmFull) afc0 = 0;
            else if (txo.c0.valid && afc0 < 127) afc0++;
            if (!rx_in.c1TxAlmFull) afc1 = 0;
            else if (txo.c1.valid && afc1 < 127) afc1++;
            if (afc0 > SL) m_v0 = 1;
            if (afc1 > SL) m_v1 = 1;
            if (err_in) m_err = 1;
            if (m_pw != pwr_in && m_pcnt < 255) m_pcnt++;
            m_pw = pwr_in;
        end
        rxq.push_back(cap ? rx_in : kill_rx(rx_in));
        void'(rxq.pop_front());
        txq.push_back((cap && !srb) ? tx_in : kill_tx(tx_in));
        void'(txq.pop_front());
    endtask

    task automatic m_compare();
        t_if_ccip_Rx er = rxq[0];
        t_if_ccip_Tx et = txq[0];
        chk("m_sr", sr_o, rel < 2 + S);
        chk("m_rx_c0af", rx_o.c0TxAlmFull, er.c0TxAlmFull);
        chk("m_rx_c1af", rx_o.c1TxAlmFull, er.c1TxAlmFull);
        chk("m_rx_c0rsp", rx_o.c0.rspValid, er.c0.rspValid);
        chk("m_rx_c0mrd", rx_o.c0.mmioRdValid, er.c0.mmioRdValid);
        chk("m_rx_c0mwr", rx_o.c0.mmioWrValid, er.c0.mmioWrValid);
        chk("m_rx_c1rsp", rx_o.c1.rspValid, er.c1.rspValid);
        if (er.c0.rspValid || er.c0.mmioRdValid || er.c0.mmioWrValid)
            chk("m_rx_c0", rx_o.c0, er.c0);
        if (er.c1.rspValid) chk("m_rx_c1", rx_o.c1, er.c1);
        chk("m_tx_c0v", tx_o.c0.valid, et.c0.valid);
        chk("m_tx_c1v", tx_o.c1.valid, et.c1.valid);
        chk("m_tx_c2v", tx_o.c2.mmioRdValid, et.c2.mmioRdValid);
        if (et.c0.valid) chk("m_tx_c0", tx_o.c0, et.c0);
        if (et.c1.valid) chk("m_tx_c1", tx_o.c1, et.c1);
        if (et.c2.mmioRdValid) chk("m_tx_c2", tx_o.c2, et.c2);
        chk("m_pwr", pwr_o, m_pw);
        chk("m_err", err_o, m_err);
        chk("m_v0", v0_o, m_v0);
        chk("m_v1", v1_o, m_v1);
        chk("m_pcnt", pcnt_o, m_pcnt);
    endtask

    initial begin
        m_reset();
        @(posedge pClk);
        forever begin
            if (!rst_n) m_reset();
            else m_edge();
            #2;
            m_compare();
            if (rx_o.c0.rspValid) begin
                beats++;
                run++;
                if (run > maxrun) maxrun = run;
            end else begin
                run = 0;
            end
            @(posedge pClk or negedge rst_n);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1);
    end

    task automatic clr();
        rx_in.c0.rspValid    = 1'b0;
        rx_in.c0.mmioRdValid = 1'b0;
        rx_in.c0.mmioWrValid = 1'b0;
        rx_in.c1.rspValid    = 1'b0;
        tx_in.c0.valid       = 1'b0;
        tx_in.c1.valid       = 1'b0;
        tx_in.c2.mmioRdValid = 1'b0;
    endtask

    task automatic af_window(input int nreq);
        @(negedge pClk);
        rx_in.c0TxAlmFull = 1'b1;
        for (int i = 0; i < nreq; i++) begin
            tx_in.c0.valid = 1'b1;
            tx_in.c0.hdr.address = 42'(32'h200 + i);
            @(negedge pClk);
        end
        tx_in.c0.valid = 1'b0;
        repeat (4) @(negedge pClk);
        rx_in.c0TxAlmFull = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int b0;
        rst_n  = 1'b1;
        err_in = 1'b0;
        pwr_in = 2'd0;
        rx_in  = '0;
        tx_in  = '0;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge pClk);
        chk("rst_sr", sr_o, 1);
        chk("rst_rx_af", rx_o.c0TxAlmFull, 1);
        chk("rst_tx_v", tx_o.c0.valid, 0);

        // reset release and stretch
        rst_n = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge pClk);
            #3;
            chk("stretch", sr_o, k < 18);
            chk("stretch_rxv", rx_o.c0.rspValid, 0);
        end

        // single-beat latency
        @(negedge pClk);
        rx_in.c0.rspValid   = 1'b1;
        rx_in.c0.hdr.mdata  = 16'h005A;
        rx_in.c0.data       = 512'hCAFE;
        tx_in.c1.valid      = 1'b1;
        tx_in.c1.hdr.address = 42'h1000;
        tx_in.c1.data       = 512'hBEEF;
        @(negedge pClk);
        clr();
        @(posedge pClk); #3;
        chk("lat_tx_v", tx_o.c1.valid, 1);
        chk("lat_tx_addr", tx_o.c1.hdr.address, 42'h1000);
        chk("lat_tx_data", tx_o.c1.data, 512'hBEEF);
        chk("lat_rx_early", rx_o.c0.rspValid, 0);
        @(posedge pClk); #3;
        chk("lat_rx_v", rx_o.c0.rspValid, 1);
        chk("lat_rx_mdata", rx_o.c0.hdr.mdata, 16'h005A);
        chk("lat_tx_gone", tx_o.c1.valid, 0);

        // 64-beat back-to-back burst
        repeat (4) @(negedge pClk);
        b0 = beats;
        for (int i = 0; i < 64; i++) begin
            @(negedge pClk);
            rx_in.c0.rspValid     = 1'b1;
            rx_in.c0.hdr.mdata    = 16'(i);
            rx_in.c0.data         = 512'(i * 3 + 1);
            rx_in.c1.rspValid     = (i % 5 == 0);
            rx_in.c1.hdr.mdata    = 16'(i + 100);
            tx_in.c0.valid        = 1'b1;
            tx_in.c0.hdr.address  = 42'(i);
            tx_in.c2.mmioRdValid  = (i == 20);
            tx_in.c2.hdr.tid      = 9'(i);
            tx_in.c2.data         = 64'(i * 7);
        end
        @(negedge pClk);
        clr();
        rx_in.c0.mmioWrValid = 1'b1;
        @(negedge pClk);
        clr();
        repeat (6) @(negedge pClk);
        chk("burst_beats", beats - b0, 64);
        chk("burst_run", maxrun, 64);

        // almost-full: 8 tolerated, windows cleared, 9 violates
        af_window(8);
        @(negedge pClk);
        chk("af8_v0", v0_o, 0);
        af_window(5);
        @(negedge pClk);
        af_window(5);
        @(negedge pClk);
        chk("afclr_v0", v0_o, 0);
        af_window(9);
        @(negedge pClk);
        chk("af9_v0", v0_o, 1);
        chk("af9_v1", v1_o, 0);

        // error pulse and power state
        err_in = 1'b1;
        @(negedge pClk);
        err_in = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge pClk);
            chk("err_sticky", err_o, 1);
        end
        chk("pwr_start", pcnt_o, 0);
        for (int k = 0; k < 5; k++) begin
            case (k)
                1, 2:    pwr_in = 2'd1;
                3:       pwr_in = 2'd2;
                default: pwr_in = 2'd0;
            endcase
            @(negedge pClk);
        end
        @(negedge pClk);
        chk("pwr_cnt3", pcnt_o, 3);
        for (int k = 0; k < 300; k++) begin
            pwr_in = (k % 2 == 0) ? 2'd1 : 2'd0;
            @(negedge pClk);
        end
        pwr_in = 2'd0;
        @(negedge pClk);
        chk("pwr_sat", pcnt_o, 255);

        // reset mid-burst with AFU valids held high
        rx_in.c0.rspValid = 1'b1;
        tx_in.c0.valid    = 1'b1;
        tx_in.c1.valid    = 1'b1;
        repeat (3) @(negedge pClk);
        rst_n = 1'b0;
        #1;
        chk("mid_rx_v", rx_o.c0.rspValid, 0);
        chk("mid_tx_v0", tx_o.c0.valid, 0);
        chk("mid_tx_v1", tx_o.c1.valid, 0);
        chk("mid_err", err_o, 0);
        chk("mid_viol", v0_o, 0);
        chk("mid_sr", sr_o, 1);
        chk("mid_pcnt", pcnt_o, 0);
        repeat (2) @(negedge pClk);
        rst_n = 1'b1;
        for (int k = 1; k <= 21; k++) begin
            @(posedge pClk);
            #3;
            chk("mid_txgate", tx_o.c0.valid, k >= 20);
        end
        @(negedge pClk);
        clr();
        repeat (8) @(negedge pClk);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/ccip_interface_pipe.md
# ccip_interface_pipe

Parametrised CCI-P boundary retiming block between the FIU-side CCI-P port and the AFU core (e.g. `nlb_lpbk`). It provides configurable Rx/Tx register depth, stretched AFU reset generation, a sticky error and power-state monitor, and per-channel almost-full protocol checking. It replaces the fixed single-stage interface register in `ccip_std_afu`.

## Interface
- `RX_STAGES`, 1: Rx pipeline depth, legal range 1..4.
- `TX_STAGES`, 1: Tx pipeline depth, legal range 1..4.
- `RST_STRETCH`, 16: cycles AFU reset stays high after external reset release, legal range 1..255.
- `ALMFULL_SLACK`, 8: Tx requests per channel tolerated while that channel's almost-full is asserted, legal range 1..63.

Ports:
- `pClk` in 1: sole clock, CCI-P domain.
- `pck_cp2af_softReset_n` in 1: asynchronous, active-low reset.
- `pck_cp2af_pwrState_T0` in 2: FIU power state.
- `pck_cp2af_error_T0` in 1: FIU protocol error pulse or level.
- `pck_cp2af_sRx_T0` in `t_if_ccip_Rx`: FIU Rx.
- `pck_af2cp_sTx_T0` in `t_if_ccip_Tx`: AFU Tx.
- `pck_cp2af_softReset_Tn` out 1: active-high reset to the AFU.
- `pck_cp2af_pwrState_Tn` out 2: registered power state.
- `pck_cp2af_error_sticky` out 1: sticky error.
- `pck_cp2af_sRx_Tn` out `t_if_ccip_Rx`: Rx to the AFU.
- `pck_af2cp_sTx_Tn` out `t_if_ccip_Tx`: Tx to the FIU.
- `c0_almfull_viol`, `c1_almfull_viol` out 1 each: sticky almost-full violation flags.
- `pwr_change_cnt` out 8: saturating count of power-state changes.

## Operation
- **Internal reset `rst_i`:**
  - Asserts asynchronously when `pck_cp2af_softReset_n`=0.
  - Deasserts through a 2-flop synchroniser.
- **Reset stretcher:**
  - 8-bit down-counter, loaded with `RST_STRETCH` while `rst_i` is asserted.
  - Decrements each cycle after release.
  - `pck_cp2af_softReset_Tn`=1 while `rst_i` is asserted or the counter is nonzero.
- **Rx pipeline:**
  - `RX_STAGES` register stages of the full struct.
  - Only valid bits are reset (`c0.rspValid`, `c0.mmioRdValid`, `c0.mmioWrValid`, `c1.rspValid`); payloads are not reset.
  - `c0TxAlmFull` and `c1TxAlmFull` are pipelined identically and reset to 1.
- **Tx pipeline:**
  - `TX_STAGES` register stages.
  - Valid bits (`c0.valid`, `c1.valid`, `c2.mmioRdValid`) are reset to 0.
  - Stage-0 valids are ANDed with `!pck_cp2af_softReset_Tn`, so no request from a resetting AFU reaches the FIU.
- **Error:** `pck_cp2af_error_sticky` sets on any cycle with `pck_cp2af_error_T0`=1 and clears only on `rst_i`.
- **Power state:**
  - `pwrState` is registered once.
  - `pwr_change_cnt` increments when the registered value differs from `pck_cp2af_pwrState_T0`, saturating at 255.
- **Almost-full checker** (one instance per channel c0/c1, observed at the FIU side):
  - `afcnt` is 7-bit.
  - While `pck_cp2af_sRx_T0.cNTxAlmFull`=1, `afcnt` increments on each `pck_af2cp_sTx_Tn.cN.valid`.
  - When almost-full=0, `afcnt` clears to 0 that cycle, and a concurrent valid is not counted.
  - `afcnt` saturates at 127.
  - `cN_almfull_viol` sets sticky when `afcnt` > `ALMFULL_SLACK` and clears only on `rst_i`.
- **Simultaneous events:** almost-full rising in the same cycle as a valid counts that valid.

## Timing
- Rx latency is exactly `RX_STAGES` cycles; Tx latency is exactly `TX_STAGES` cycles; both have full throughput and no back-pressure.
- Values on all outputs during and after reset until driven:
  - valids 0
  - almost-fulls 1
  - `pck_cp2af_softReset_Tn` 1
  - `pwrState_Tn` 0
  - sticky flags 0
  - `pwr_change_cnt` 0
- `pck_cp2af_softReset_Tn` falls on the (2+`RST_STRETCH`)th `pClk` rising edge after the reset release edge. Re-asserting reset mid-stretch restarts the full sequence.
- Reset asserted mid-stream: all in-flight valids vanish asynchronously, and payload registers hold stale data with valid=0.
- Sticky flags are visible the cycle after the triggering edge.

## Test plan
- **Reset release:** release reset with `RST_STRETCH`=16 -> `pck_cp2af_softReset_Tn` is 1 for 18 cycles and 0 on cycle 18; all valids 0 throughout.
- **Latency:** `RX_STAGES`=3, `TX_STAGES`=2, one `c0.rspValid` with mdata 0x5A and one `c1.valid` with address 0x1000 -> Rx appears at +3 cycles, Tx at +2 cycles, payloads unchanged; back-to-back 64 beats pass with no gaps.
- **Almost-full violation:** `c0TxAlmFull` held 1 and AFU issues 9 consecutive `c0.valid` with `ALMFULL_SLACK`=8 -> `c0_almfull_viol`=1 after the 9th request reaches the FIU; 8 requests -> flag stays 0; `c1_almfull_viol` stays 0.
- **Counter clear:** almost-full toggles 1 (5 requests), 0, 1 (5 requests) -> no violation.
- **Error and power state:** `pck_cp2af_error_T0` pulsed for 1 cycle -> sticky flag holds until reset. `pwrState` sequence 0,1,1,2,0 -> `pwr_change_cnt`=3. 300 toggles -> count reads 255.
- **Reset mid-operation:** reset asserted mid-burst, while AFU valids are held high during the stretch window -> outputs drop to 0 immediately; no Tx valid appears at `pck_af2cp_sTx_Tn` until the stretch ends + `TX_STAGES`; sticky flags cleared.
